// File: rtl/lab7_pkg.sv
// Shared constants for the detection-count display: digit count, active-low
// seven-segment codes {g,f,e,d,c,b,a}, and the BCD digit increment helper.
package lab7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_IDLE   = 4'b1111;

  typedef enum logic [1:0] {
    DIG_ONES      = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } dig_sel_e;

  // Returns {carry_out, next_digit}; 9 rolls to 0 with carry.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    logic [4:0] r;
    if (d >= 4'd9) r = {1'b1, 4'd0};
    else           r = {1'b0, d + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-BCD
// nibbles blank the digit.
module seg7_decode
  import lab7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mealy_count_display.sv
// Counts registered detector hits in a 4-digit BCD counter with sticky wrap
// flag, and scans the count onto a multiplexed active-low 7-segment display.
module mealy_count_display
  import lab7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        z,
  output logic [15:0] count_bcd,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic             z_q;
  logic [15:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  dig_sel_e         dig_sel_q, dig_sel_d;
  logic             ref_tc;
  logic             carry;
  logic [4:0]       inc;
  logic [3:0]       nibble;

  // Ripple the +1 through all digits in one cycle; carry out of the top digit
  // is the 9999 -> 0000 wrap.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    carry   = z_q;
    inc     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        inc                = bcd_digit_inc(count_q[4*i +: 4]);
        count_d[4*i +: 4]  = inc[3:0];
        carry              = inc[4];
      end
    end
    if (carry) ovf_d = 1'b1;
  end

  always_comb begin
    ref_tc    = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_tc ? '0 : ref_cnt_q + 1'b1;
    dig_sel_d = dig_sel_q;
    if (ref_tc) begin
      case (dig_sel_q)
        DIG_ONES:      dig_sel_d = DIG_TENS;
        DIG_TENS:      dig_sel_d = DIG_HUNDREDS;
        DIG_HUNDREDS:  dig_sel_d = DIG_THOUSANDS;
        DIG_THOUSANDS: dig_sel_d = DIG_ONES;
        default:       dig_sel_d = DIG_ONES;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q       <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ref_cnt_q <= '0;
      dig_sel_q <= DIG_ONES;
    end else begin
      z_q       <= z;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ref_cnt_q <= ref_cnt_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  always_comb begin
    an     = AN_IDLE;
    nibble = count_q[3:0];
    case (dig_sel_q)
      DIG_ONES:      begin an = 4'b1110; nibble = count_q[3:0];   end
      DIG_TENS:      begin an = 4'b1101; nibble = count_q[7:4];   end
      DIG_HUNDREDS:  begin an = 4'b1011; nibble = count_q[11:8];  end
      DIG_THOUSANDS: begin an = 4'b0111; nibble = count_q[15:12]; end
      default:       begin an = AN_IDLE; nibble = count_q[3:0];   end
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd_i (nibble),
    .seg_o (seg)
  );

  assign count_bcd = count_q;
  assign ovf       = ovf_q;

endmodule
